// File: rtl/pwm_capture.sv
// Three-channel PWM period/high-time capture with an Avalon-MM register view.
// Each channel is synchronized, edge-detected and measured rising-edge to rising-edge.
module pwm_capture #(
  parameter int CNT_WIDTH = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [2:0]  avs_address,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  input  logic [2:0]  pwm_in
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_NEAR = CNT_MAX - CNT_ONE;

  logic [2:0]           sync1_q, sync2_q, prev_q;
  logic [2:0]           rise_s;
  logic                 enable_q, enable_d;
  logic                 ctrl_wr_s, clear_s;
  logic [CNT_WIDTH-1:0] period_cnt_q [3];
  logic [CNT_WIDTH-1:0] period_cnt_d [3];
  logic [CNT_WIDTH-1:0] high_cnt_q   [3];
  logic [CNT_WIDTH-1:0] high_cnt_d   [3];
  logic [CNT_WIDTH-1:0] period_cap_q [3];
  logic [CNT_WIDTH-1:0] period_cap_d [3];
  logic [CNT_WIDTH-1:0] high_cap_q   [3];
  logic [CNT_WIDTH-1:0] high_cap_d   [3];
  logic [2:0]           armed_q, armed_d;
  logic [2:0]           valid_q, valid_d;
  logic [2:0]           stale_q, stale_d;
  logic [31:0]          rd_mux_s;
  logic [31:0]          readdata_q, readdata_d;
  logic                 unused_wdata_s;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                   input logic inc);
    if (inc && (v != CNT_MAX)) begin
      return v + CNT_ONE;
    end else begin
      return v;
    end
  endfunction

  function automatic logic [31:0] zext(input logic [CNT_WIDTH-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[CNT_WIDTH-1:0] = v;
    return r;
  endfunction

  assign rise_s         = sync2_q & ~prev_q;
  assign ctrl_wr_s      = avs_write && (avs_address == 3'd7);
  assign clear_s        = ctrl_wr_s && avs_writedata[1];
  assign enable_d       = ctrl_wr_s ? avs_writedata[0] : enable_q;
  assign unused_wdata_s = ^avs_writedata[31:2];
  assign avs_readdata   = readdata_q;

  // Per-channel counter, capture and status next-state; clear beats everything.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      period_cnt_d[i] = period_cnt_q[i];
      high_cnt_d[i]   = high_cnt_q[i];
      period_cap_d[i] = period_cap_q[i];
      high_cap_d[i]   = high_cap_q[i];
      armed_d[i]      = armed_q[i];
      valid_d[i]      = valid_q[i];
      stale_d[i]      = stale_q[i];
      if (clear_s) begin
        period_cnt_d[i] = CNT_ZERO;
        high_cnt_d[i]   = CNT_ZERO;
        period_cap_d[i] = CNT_ZERO;
        high_cap_d[i]   = CNT_ZERO;
        armed_d[i]      = 1'b0;
        valid_d[i]      = 1'b0;
        stale_d[i]      = 1'b0;
      end else if (!enable_q) begin
        period_cnt_d[i] = CNT_ZERO;
        high_cnt_d[i]   = CNT_ZERO;
        armed_d[i]      = 1'b0;
      end else if (rise_s[i]) begin
        period_cnt_d[i] = CNT_ONE;
        high_cnt_d[i]   = CNT_ONE;
        if (armed_q[i]) begin
          period_cap_d[i] = period_cnt_q[i];
          high_cap_d[i]   = high_cnt_q[i];
          valid_d[i]      = 1'b1;
          stale_d[i]      = 1'b0;
        end else begin
          armed_d[i] = 1'b1;
        end
      end else begin
        period_cnt_d[i] = sat_inc(period_cnt_q[i], 1'b1);
        high_cnt_d[i]   = sat_inc(high_cnt_q[i], sync2_q[i]);
        // Disarm as the period counter lands on saturation so no bogus period is captured.
        if (period_cnt_q[i] >= CNT_NEAR) begin
          stale_d[i] = 1'b1;
          armed_d[i] = 1'b0;
        end else begin
          stale_d[i] = stale_q[i];
        end
      end
    end
  end

  // Register-map read mux and one-cycle read-data hold.
  always_comb begin
    rd_mux_s = 32'd0;
    case (avs_address)
      3'd0:    rd_mux_s = zext(high_cap_q[0]);
      3'd1:    rd_mux_s = zext(period_cap_q[0]);
      3'd2:    rd_mux_s = zext(high_cap_q[1]);
      3'd3:    rd_mux_s = zext(period_cap_q[1]);
      3'd4:    rd_mux_s = zext(high_cap_q[2]);
      3'd5:    rd_mux_s = zext(period_cap_q[2]);
      3'd6:    rd_mux_s = {26'd0, stale_q, valid_q};
      3'd7:    rd_mux_s = {31'd0, enable_q};
      default: rd_mux_s = 32'd0;
    endcase
    if (avs_read) begin
      readdata_d = rd_mux_s;
    end else begin
      readdata_d = readdata_q;
    end
  end

  // All state registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 3'b000;
      sync2_q    <= 3'b000;
      prev_q     <= 3'b000;
      enable_q   <= 1'b1;
      armed_q    <= 3'b000;
      valid_q    <= 3'b000;
      stale_q    <= 3'b000;
      readdata_q <= 32'd0;
      for (int i = 0; i < 3; i++) begin
        period_cnt_q[i] <= CNT_ZERO;
        high_cnt_q[i]   <= CNT_ZERO;
        period_cap_q[i] <= CNT_ZERO;
        high_cap_q[i]   <= CNT_ZERO;
      end
    end else begin
      sync1_q    <= pwm_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      enable_q   <= enable_d;
      armed_q    <= armed_d;
      valid_q    <= valid_d;
      stale_q    <= stale_d;
      readdata_q <= readdata_d;
      for (int i = 0; i < 3; i++) begin
        period_cnt_q[i] <= period_cnt_d[i];
        high_cnt_q[i]   <= high_cnt_d[i];
        period_cap_q[i] <= period_cap_d[i];
        high_cap_q[i]   <= high_cap_d[i];
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized/directed bench for pwm_capture: a 24-bit and an 8-bit instance share
// stimulus and are compared every cycle against a time-stamp based behavioural model.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst;
  logic        avs_read, avs_write;
  logic [2:0]  avs_address;
  logic [31:0] avs_writedata;
  logic [2:0]  pwm_in;
  logic [31:0] rd0, rd1;

  always #5 clk = ~clk;

  pwm_capture #(.CNT_WIDTH(24)) u_dut24 (
    .clk(clk), .rst(rst), .avs_read(avs_read), .avs_write(avs_write),
    .avs_address(avs_address), .avs_writedata(avs_writedata),
    .avs_readdata(rd0), .pwm_in(pwm_in));

  pwm_capture #(.CNT_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .avs_read(avs_read), .avs_write(avs_write),
    .avs_address(avs_address), .avs_writedata(avs_writedata),
    .avs_readdata(rd1), .pwm_in(pwm_in));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  // A channel's count is described by a reference edge (ref_k) and the value the count
  // took there (ref_v); high time is the number of synchronized-high cycles in the window.
  int          cmax [2] = '{16777215, 255};
  logic [2:0]  s_hist  [0:65535];
  logic [2:0]  in_hist [0:65535];
  int          k = 0;
  int          last_rst = 0;
  int          m_per [2][3];
  int          m_hi  [2][3];
  int          m_refk[2][3];
  int          m_refv[2][3];
  bit          m_armed[2][3];
  bit          m_valid[2][3];
  bit          m_stale[2][3];
  bit          m_en [2];
  logic [31:0] m_rd [2] = '{32'd0, 32'd0};
  bit          cmp_on = 1'b0;

  function automatic logic [31:0] reg_view(input int u, input logic [2:0] a);
    logic [31:0] v;
    v = 32'd0;
    case (a)
      3'd0: v = m_hi[u][0];
      3'd1: v = m_per[u][0];
      3'd2: v = m_hi[u][1];
      3'd3: v = m_per[u][1];
      3'd4: v = m_hi[u][2];
      3'd5: v = m_per[u][2];
      3'd6: for (int c = 0; c < 3; c++) begin v[c] = m_valid[u][c]; v[3+c] = m_stale[u][c]; end
      default: v[0] = m_en[u];
    endcase
    return v;
  endfunction

  always @(posedge clk) begin : model
    logic [2:0] rise;
    int cb, hb;
    bit ctrl;
    s_hist[k] = pwm_in;
    if (rst) last_rst = k;
    if (rst || (k - last_rst) <= 2) in_hist[k] = 3'b000;
    else in_hist[k] = s_hist[k-2];
    rise = rst ? 3'b000 : (in_hist[k] & ~in_hist[k-1]);
    ctrl = avs_write && (avs_address == 3'd7);
    for (int u = 0; u < 2; u++) begin
      if (rst) begin
        m_rd[u] = 32'd0;
        m_en[u] = 1'b1;
        for (int c = 0; c < 3; c++) begin
          m_per[u][c] = 0; m_hi[u][c] = 0; m_refk[u][c] = k; m_refv[u][c] = 0;
          m_armed[u][c] = 0; m_valid[u][c] = 0; m_stale[u][c] = 0;
        end
      end else begin
        if (avs_read) m_rd[u] = reg_view(u, avs_address);
        for (int c = 0; c < 3; c++) begin
          cb = m_refv[u][c] + (k - 1 - m_refk[u][c]);
          if (cb > cmax[u]) cb = cmax[u];
          if (ctrl && avs_writedata[1]) begin
            m_per[u][c] = 0; m_hi[u][c] = 0; m_refk[u][c] = k; m_refv[u][c] = 0;
            m_armed[u][c] = 0; m_valid[u][c] = 0; m_stale[u][c] = 0;
          end else if (!m_en[u]) begin
            m_armed[u][c] = 0; m_refk[u][c] = k; m_refv[u][c] = 0;
          end else if (rise[c]) begin
            if (m_armed[u][c]) begin
              hb = m_refv[u][c];
              for (int j = m_refk[u][c] + 1; j < k; j++) hb += int'(in_hist[j][c]);
              if (hb > cmax[u]) hb = cmax[u];
              m_per[u][c] = cb; m_hi[u][c] = hb; m_valid[u][c] = 1; m_stale[u][c] = 0;
            end else begin
              m_armed[u][c] = 1;
            end
            m_refk[u][c] = k; m_refv[u][c] = 1;
          end else if (cb >= cmax[u] - 1) begin
            m_stale[u][c] = 1; m_armed[u][c] = 0;
          end
        end
        if (ctrl) m_en[u] = avs_writedata[0];
      end
    end
    k++;
  end

  // Every-cycle comparison of both read-data ports against the model.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("rdata_w24", rd0, m_rd[0]);
      check("rdata_w8", rd1, m_rd[1]);
    end
  end

  // ---------------- stimulus ----------------
  int gp[3], gh[3], gph[3];
  bit rnd_bus = 1'b0;
  logic [31:0] ctl_tab [6] = '{32'h1, 32'h1, 32'h1, 32'h3, 32'h0, 32'h2};

  task automatic set_gen(input int c, input int p, input int h);
    gp[c] = p; gh[c] = h; gph[c] = 0;
  endtask

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (gp[i] == 0) pwm_in[i] = 1'b0;
      else begin
        pwm_in[i] = (gph[i] < gh[i]);
        gph[i] = (gph[i] + 1) % gp[i];
      end
    end
    if (rnd_bus) begin
      avs_read      = 1'($urandom_range(1, 0));
      avs_write     = ($urandom_range(7, 0) == 0);
      avs_address   = 3'($urandom_range(7, 0));
      avs_writedata = $urandom;
      if (avs_write && avs_address == 3'd7) avs_writedata = ctl_tab[$urandom_range(5, 0)];
    end
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_ph(input int t);
    for (int n = 0; n < 200; n++) begin
      if (gph[0] == t) break;
      step();
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    step(); avs_write = 1'b1; avs_address = a; avs_writedata = d;
    step(); avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v0, output logic [31:0] v1);
    step(); avs_read = 1'b1; avs_address = a;
    step(); avs_read = 1'b0;
    v0 = rd0; v1 = rd1;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string name);
    logic [31:0] v0, v1;
    rd(a, v0, v1);
    check(name, v0, exp);
  endtask

  task automatic pulse_rst();
    step(); rst = 1'b1;
    step(); rst = 1'b0;
  endtask

  initial begin
    logic [31:0] v0, v1;
    int p, h;
    rst = 1'b1; avs_read = 1'b0; avs_write = 1'b0; avs_address = 3'd0;
    avs_writedata = 32'd0; pwm_in = 3'b000;
    for (int c = 0; c < 3; c++) set_gen(c, 0, 0);
    run(3);
    rst = 1'b0;
    cmp_on = 1'b1;

    for (int a = 0; a < 7; a++) rd_chk(3'(a), 32'd0, "reset_reg");
    rd_chk(3'd7, 32'h1, "reset_ctrl");

    set_gen(0, 100, 25);
    run(310);
    rd_chk(3'd0, 32'd25, "ch0_high");
    rd_chk(3'd1, 32'd100, "ch0_period");
    rd_chk(3'd6, 32'h01, "ch0_status");

    // Reset while the input is low, mid-period.
    wait_ph(60);
    pulse_rst();
    for (int a = 0; a < 7; a++) rd_chk(3'(a), 32'd0, "midrst_reg");
    rd_chk(3'd7, 32'h1, "midrst_ctrl");
    run(230);
    rd_chk(3'd0, 32'd25, "postrst_high");
    rd_chk(3'd1, 32'd100, "postrst_period");
    rd_chk(3'd6, 32'h01, "postrst_status");

    wr(3'd7, 32'h2);
    for (int a = 0; a < 6; a++) rd_chk(3'(a), 32'd0, "clear_reg");
    rd_chk(3'd6, 32'd0, "clear_status");
    rd_chk(3'd7, 32'd0, "clear_ctrl");
    wait_ph(50);
    wr(3'd7, 32'h1);
    wait_ph(10);
    rd_chk(3'd6, 32'd0, "first_edge_arms");
    wait_ph(10);
    rd_chk(3'd6, 32'h01, "second_edge_valid");
    rd_chk(3'd1, 32'd100, "second_edge_period");

    wr(3'd7, 32'h0);
    set_gen(0, 40, 10);
    run(200);
    rd_chk(3'd0, 32'd25, "disabled_high");
    rd_chk(3'd1, 32'd100, "disabled_period");
    rd_chk(3'd7, 32'd0, "disabled_ctrl");
    wr(3'd7, 32'h1);
    run(100);
    rd_chk(3'd0, 32'd10, "reenable_high");
    rd_chk(3'd1, 32'd40, "reenable_period");
    rd_chk(3'd7, 32'h1, "reenable_ctrl");

    step(); rst = 1'b1;
    set_gen(0, 0, 0); set_gen(1, 1000, 999); set_gen(2, 7, 1);
    step(); rst = 1'b0;
    run(2100);
    rd_chk(3'd2, 32'd999, "ch1_high");
    rd_chk(3'd3, 32'd1000, "ch1_period");
    rd_chk(3'd4, 32'd1, "ch2_high");
    rd_chk(3'd5, 32'd7, "ch2_period");
    rd_chk(3'd6, 32'h06, "ch12_status");

    // Saturation on the 8-bit instance.
    step(); rst = 1'b1;
    set_gen(0, 50, 20); set_gen(1, 0, 0); set_gen(2, 0, 0);
    step(); rst = 1'b0;
    run(160);
    rd(3'd1, v0, v1); check("w8_period50", v1, 32'd50);
    rd(3'd0, v0, v1); check("w8_high20", v1, 32'd20);
    set_gen(0, 0, 0);
    run(300);
    rd(3'd6, v0, v1); check("w8_stale_valid", v1 & 32'h9, 32'h9);
    rd(3'd1, v0, v1); check("w8_period_kept", v1, 32'd50);
    set_gen(0, 60, 30);
    run(135);
    rd(3'd6, v0, v1); check("w8_stale_cleared", v1 & 32'h9, 32'h1);
    rd(3'd1, v0, v1); check("w8_period60", v1, 32'd60);
    rd(3'd0, v0, v1); check("w8_high30", v1, 32'd30);

    rnd_bus = 1'b1;
    repeat (6) begin
      for (int c = 0; c < 3; c++) begin
        p = $urandom_range(40, 2);
        h = $urandom_range(p - 1, 1);
        set_gen(c, p, h);
      end
      run(500);
    end
    rnd_bus = 1'b0;
    step();
    avs_read = 1'b0; avs_write = 1'b0;
    run(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
